romload_sink: RTL

ROMLOAD_SINK -- requirements
Module: romload_sink

---
 rtl/romload_sink_pkg.sv | 29 ++
 rtl/romload_fifo.sv | 50 +++++
 rtl/romload_sink.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/romload_sink_pkg.sv
// Shared load-mode encodings, FSM state type and the queued write-word layout for romload_sink.
package romload_sink_pkg;

  localparam logic [2:0] LOAD_IDLE = 3'd0;
  localparam logic [2:0] LOAD_ROM  = 3'd1;
  localparam logic [2:0] LOAD_CRAM = 3'd2;
  localparam logic [2:0] LOAD_CFG  = 3'd3;
  localparam logic [2:0] LOAD_BIOS = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StFlush
  } state_e;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } word_t;

  localparam int unsigned WordWidth = $bits(word_t);

  // Encodings above LOAD_BIOS are not real modes and behave as idle.
  function automatic logic [2:0] decode_mode(input logic [2:0] m);
    return (m > LOAD_BIOS) ? LOAD_IDLE : m;
  endfunction

endpackage

// File: rtl/romload_fifo.sv
// Synchronous word FIFO with show-ahead read; push while full is accepted only alongside a pop.
module romload_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 41
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AW:0] FullCount = Depth[AW:0];

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == FullCount);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/romload_sink.sv
// Byte-stream loader: packs bytes into 16-bit SDRAM writes, captures config words and
// (with ROMLOAD_HEADER_EN defined) the first 64 header bytes of a ROM load.
module romload_sink
  import romload_sink_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [22:0] ROM_BASE   = 23'h000000,
  parameter logic [22:0] CRAM_BASE  = 23'h700000,
  parameter logic [22:0] BIOS_BASE  = 23'h680000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [2:0]  rom_loading,
  input  logic [7:0]  rom_do,
  input  logic        rom_do_valid,
  output logic        mem_req,
  output logic [22:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  output logic [31:0] cfg,
  output logic [22:0] rom_size,
  output logic        load_done,
  output logic        overflow,
  input  logic [5:0]  hdr_addr,
  output logic [7:0]  hdr_data
);

  state_e      state_q, state_d;
  logic [2:0]  mode, cur_mode_q;
  logic [22:0] count_q, wr_addr_q, rom_size_q, base;
  logic [31:0] cfg_q;
  logic [7:0]  held_q;
  logic        odd_q, overflow_q, load_done_q;
  logic        enter_load, finish, byte_acc, push_req, drop;
  word_t       push_word, head;
  logic        fifo_full, fifo_empty, fifo_pop;

  assign mode     = decode_mode(rom_loading);
  assign byte_acc = (state_q == StLoad) && rom_do_valid;

  always_comb begin
    state_d    = state_q;
    enter_load = 1'b0;
    finish     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mode != LOAD_IDLE) begin
          state_d    = StLoad;
          enter_load = 1'b1;
        end
      end
      StLoad: begin
        if (mode != cur_mode_q) state_d = StFlush;
      end
      StFlush: begin
        // mem_req mirrors FIFO non-empty, so an empty FIFO also means no write in flight.
        if (!odd_q && fifo_empty) begin
          state_d = StIdle;
          finish  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    unique case (mode)
      LOAD_ROM:  base = ROM_BASE;
      LOAD_CRAM: base = CRAM_BASE;
      LOAD_BIOS: base = BIOS_BASE;
      default:   base = '0;
    endcase
  end

  always_comb begin
    push_req       = 1'b0;
    push_word.addr = wr_addr_q;
    push_word.data = {rom_do, held_q};
    push_word.be   = 2'b11;
    if (byte_acc && (cur_mode_q != LOAD_CFG) && odd_q) begin
      push_req = 1'b1;
    end else if ((state_q == StFlush) && odd_q) begin
      push_req       = 1'b1;
      push_word.data = {8'h00, held_q};
      push_word.be   = 2'b01;
    end
  end

  assign fifo_pop = !fifo_empty && mem_ack;
  assign drop     = push_req && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur_mode_q  <= LOAD_IDLE;
      count_q     <= '0;
      wr_addr_q   <= '0;
      rom_size_q  <= '0;
      cfg_q       <= '0;
      held_q      <= '0;
      odd_q       <= 1'b0;
      overflow_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= finish;
      if (finish) rom_size_q <= count_q;
      if (enter_load) begin
        cur_mode_q <= mode;
        count_q    <= '0;
        odd_q      <= 1'b0;
        overflow_q <= 1'b0;
        wr_addr_q  <= {base[22:1], 1'b0};
        if (mode == LOAD_CFG) cfg_q <= '0;
      end else begin
        if (byte_acc) begin
          if (count_q != 23'h7FFFFF) count_q <= count_q + 23'd1;
          if (cur_mode_q == LOAD_CFG) begin
            cfg_q <= {cfg_q[23:0], rom_do};
          end else begin
            odd_q <= !odd_q;
            if (!odd_q) held_q <= rom_do;
          end
        end
        if ((state_q == StFlush) && odd_q) odd_q <= 1'b0;
        // Dropped words still consume their address slot.
        if (push_req) wr_addr_q <= wr_addr_q + 23'd2;
        if (drop)     overflow_q <= 1'b1;
      end
    end
  end

  romload_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (WordWidth)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .wdata  (push_word),
    .pop    (fifo_pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Outputs are zeroed while idle so stale FIFO contents never show on the bus.
  assign mem_req   = !fifo_empty;
  assign mem_addr  = fifo_empty ? '0 : head.addr;
  assign mem_wdata = fifo_empty ? '0 : head.data;
  assign mem_be    = fifo_empty ? '0 : head.be;
  assign cfg       = cfg_q;
  assign rom_size  = rom_size_q;
  assign load_done = load_done_q;
  assign overflow  = overflow_q;

`ifdef ROMLOAD_HEADER_EN
  logic [7:0] hdr_q [64];

  always_ff @(posedge clk) begin
    if (byte_acc && (cur_mode_q == LOAD_ROM) && (count_q < 23'd64)) begin
      hdr_q[count_q[5:0]] <= rom_do;
    end
  end

  assign hdr_data = hdr_q[hdr_addr];
`else
  logic unused_hdr_addr;
  assign unused_hdr_addr = ^hdr_addr;
  assign hdr_data        = 8'h00;
`endif

endmodule
